// File: rtl/genius_seq_ctrl.sv
// genius_seq_ctrl: Simon-style game sequencer.
// Grows a random colour sequence one step per round, plays it on four LEDs
// with timed on/off phases, checks the player's echo and reports level,
// loss and win. Owns the sequence memory, the LFSR, the display prescaler
// and the main FSM.
// Optional feature: define GENIUS_TIMEOUT_EN to make WAIT_IN give up after
// TIMEOUT_TICKS display ticks without a press (the game is then lost).
module genius_seq_ctrl #(
    parameter int         MAX_LEN       = 16,
    parameter int         TICK_DIV      = 25000000,
    parameter logic [7:0] SEED          = 8'hA5,
    parameter int         TIMEOUT_TICKS = 10
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       i_start,
    input  logic [3:0] i_btn,
    output logic [3:0] o_leds,
    output logic [4:0] o_level,
    output logic [2:0] o_state,
    output logic       o_busy,
    output logic       o_game_over,
    output logic       o_win
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADD      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_GAP      = 3'd5,
        ST_LOSE     = 3'd6,
        ST_WIN      = 3'd7
    } state_t;

    localparam int              PW        = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0]      LEN_MAX   = 5'(MAX_LEN);

    state_t        state_reg;
    logic [4:0]    len_reg;
    logic [4:0]    idx_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    lfsr_reg;

    // Sized to the full 5-bit index range so every index is in bounds;
    // only entries below len_reg are ever read.
    logic [1:0]    mem [0:31];

    logic          tick;
    logic          btn_onehot;
    logic          last_step;
    logic          mem_we;
    logic [1:0]    cur_col;
    logic [1:0]    next_col;
    logic [1:0]    first_col;

`ifdef GENIUS_TIMEOUT_EN
    localparam int            TW        = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    logic [TW-1:0] tout_reg;
`endif

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign tick       = (presc_reg == TICK_LAST);
    assign btn_onehot = (i_btn != 4'd0) && ((i_btn & (i_btn - 4'd1)) == 4'd0);
    assign last_step  = (idx_reg == len_reg - 5'd1);
    assign mem_we     = (state_reg == ST_ADD);
    assign cur_col    = mem[idx_reg];
    assign next_col   = mem[idx_reg + 5'd1];
    // In the first round the colour is being written this very cycle, so
    // forward it straight from the LFSR instead of reading stale memory.
    assign first_col  = (len_reg == 5'd0) ? lfsr_reg[1:0] : mem[0];

    assign o_state = state_reg;
    assign o_level = len_reg;

    // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    // Sequence memory: append the new colour during ADD.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[len_reg] <= lfsr_reg[1:0];
        end
    end

    // Main FSM with prescaler and registered outputs; every state change
    // restarts the prescaler so each phase lasts exactly TICK_DIV cycles.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= ST_IDLE;
            len_reg     <= 5'd0;
            idx_reg     <= 5'd0;
            presc_reg   <= '0;
            o_leds      <= 4'd0;
            o_busy      <= 1'b0;
            o_game_over <= 1'b0;
            o_win       <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
            tout_reg    <= '0;
`endif
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            case (state_reg)
                ST_IDLE, ST_LOSE, ST_WIN: begin
                    if (i_start) begin
                        state_reg   <= ST_ADD;
                        presc_reg   <= '0;
                        len_reg     <= 5'd0;
                        idx_reg     <= 5'd0;
                        o_game_over <= 1'b0;
                        o_win       <= 1'b0;
                        o_busy      <= 1'b1;
                        o_leds      <= 4'd0;
                    end else if (state_reg == ST_WIN && tick) begin
                        o_leds <= ~o_leds;
                    end
                end
                ST_ADD: begin
                    len_reg   <= len_reg + 5'd1;
                    idx_reg   <= 5'd0;
                    state_reg <= ST_SHOW_ON;
                    presc_reg <= '0;
                    o_leds    <= onehot(first_col);
                end
                ST_SHOW_ON: begin
                    if (tick) begin
                        state_reg <= ST_SHOW_OFF;
                        presc_reg <= '0;
                        o_leds    <= 4'd0;
                    end
                end
                ST_SHOW_OFF: begin
                    if (tick) begin
                        presc_reg <= '0;
                        if (last_step) begin
                            idx_reg   <= 5'd0;
                            state_reg <= ST_WAIT_IN;
`ifdef GENIUS_TIMEOUT_EN
                            tout_reg  <= '0;
`endif
                        end else begin
                            idx_reg   <= idx_reg + 5'd1;
                            state_reg <= ST_SHOW_ON;
                            o_leds    <= onehot(next_col);
                        end
                    end
                end
                ST_WAIT_IN: begin
                    if (i_btn != 4'd0) begin
                        if (!btn_onehot || i_btn != onehot(cur_col)) begin
                            state_reg   <= ST_LOSE;
                            presc_reg   <= '0;
                            o_game_over <= 1'b1;
                            o_leds      <= 4'hF;
                            o_busy      <= 1'b0;
                        end else if (!last_step) begin
                            idx_reg  <= idx_reg + 5'd1;
`ifdef GENIUS_TIMEOUT_EN
                            tout_reg <= '0;
`endif
                        end else if (len_reg == LEN_MAX) begin
                            state_reg <= ST_WIN;
                            presc_reg <= '0;
                            o_win     <= 1'b1;
                            o_leds    <= 4'b0101;
                            o_busy    <= 1'b0;
                        end else begin
                            state_reg <= ST_GAP;
                            presc_reg <= '0;
                        end
                    end
`ifdef GENIUS_TIMEOUT_EN
                    else if (tick) begin
                        if (tout_reg == TOUT_LAST) begin
                            state_reg   <= ST_LOSE;
                            presc_reg   <= '0;
                            o_game_over <= 1'b1;
                            o_leds      <= 4'hF;
                            o_busy      <= 1'b0;
                        end else begin
                            tout_reg <= tout_reg + 1'b1;
                        end
                    end
`endif
                end
                ST_GAP: begin
                    if (tick) begin
                        state_reg <= ST_ADD;
                        presc_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// Directed bench for genius_seq_ctrl with TICK_DIV=4. One instance with the
// default game length, a second with MAX_LEN=2 for the win path.
module tb_genius_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start, w_start;
    logic [3:0] i_btn, w_btn;

    logic [3:0] leds, w_leds;
    logic [4:0] level, w_level;
    logic [2:0] state, w_state;
    logic       busy, w_busy, go, w_go, win, w_win;

    logic [7:0] m_lfsr;
    logic [1:0] c0, c1, wc0, wc1;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    genius_seq_ctrl #(.MAX_LEN(16), .TICK_DIV(4), .SEED(8'hA5), .TIMEOUT_TICKS(3)) dut (
        .CLOCK_50(clk), .RST_N(rst_n), .i_start(i_start), .i_btn(i_btn),
        .o_leds(leds), .o_level(level), .o_state(state), .o_busy(busy),
        .o_game_over(go), .o_win(win)
    );

    genius_seq_ctrl #(.MAX_LEN(2), .TICK_DIV(4), .SEED(8'hA5), .TIMEOUT_TICKS(3)) dut_w (
        .CLOCK_50(clk), .RST_N(rst_n), .i_start(w_start), .i_btn(w_btn),
        .o_leds(w_leds), .o_level(w_level), .o_state(w_state), .o_busy(w_busy),
        .o_game_over(w_go), .o_win(w_win)
    );

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, one shift per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; w_start = 1'b0; i_btn = 4'd0; w_btn = 4'd0;
        cyc(2);
        check("rst_state", state, 8'd0);
        check("rst_leds", leds, 8'd0);
        check("rst_level", level, 8'd0);
        check("rst_busy", busy, 8'd0);
        check("rst_go", go, 8'd0);
        check("rst_win", win, 8'd0);
        rst_n = 1'b1;
        cyc(3);
        check("idle_hold", state, 8'd0);

        // Reset asserted in the middle of a SHOW_ON phase
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        check("add_state", state, 8'd1);
        cyc(2);
        check("show_before_rst", state, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", state, 8'd0);
        check("midrst_leds", leds, 8'd0);
        check("midrst_level", level, 8'd0);
        check("midrst_busy", busy, 8'd0);
        cyc(1); rst_n = 1'b1;
        cyc(5);
        check("idle_after_rst", state, 8'd0);

        // Game 1, round 1
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        c0 = m_lfsr[1:0];
        check("g1_add", state, 8'd1);
        check("g1_busy", busy, 8'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("r1_on_state", state, 8'd2);
            check("r1_on_leds", leds, oh(c0));
        end
        check("r1_level", level, 8'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("r1_off_state", state, 8'd3);
            check("r1_off_leds", leds, 8'd0);
            if (k == 0) i_btn = 4'b0011;
            else        i_btn = 4'd0;
        end
        cyc(1);
        check("r1_wait", state, 8'd4);
        // Correct press with a simultaneous start: start must be ignored
        i_btn = oh(c0); i_start = 1'b1; cyc(1); i_btn = 4'd0; i_start = 1'b0;
        check("r1_gap", state, 8'd5);
        check("r1_gap_leds", leds, 8'd0);
        cyc(3);
        check("r1_gap_end", state, 8'd5);
        cyc(1);
        check("r2_add", state, 8'd1);
        c1 = m_lfsr[1:0];

        // Round 2: replay of both colours
        cyc(1);
        check("r2_level", level, 8'd2);
        check("r2_first", leds, oh(c0));
        cyc(4);
        check("r2_gap1", leds, 8'd0);
        cyc(4);
        check("r2_second", leds, oh(c1));
        cyc(8);
        check("r2_wait", state, 8'd4);
        i_btn = oh(c0); cyc(1);
        check("r2_mid_echo", state, 8'd4);
        i_btn = oh(c1); cyc(1); i_btn = 4'd0;
        check("r2_gap", state, 8'd5);
        cyc(4);
        check("r3_add", state, 8'd1);
        cyc(1);
        check("r3_level", level, 8'd3);
        cyc(24);
        check("r3_wait", state, 8'd4);

        // Double press loses; level held, buttons then ignored
        i_btn = 4'b0011; cyc(1); i_btn = 4'd0;
        check("dbl_state", state, 8'd6);
        check("dbl_go", go, 8'd1);
        check("dbl_leds", leds, 8'hF);
        check("dbl_level", level, 8'd3);
        check("dbl_busy", busy, 8'd0);
        cyc(3);
        i_btn = oh(c0); cyc(1); i_btn = 4'd0;
        check("lose_btn_ignored", state, 8'd6);

        // Restart from LOSE, then lose on a wrong colour
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        c0 = m_lfsr[1:0];
        check("restart_state", state, 8'd1);
        check("restart_go", go, 8'd0);
        cyc(1);
        check("restart_level", level, 8'd1);
        check("restart_leds", leds, oh(c0));
        cyc(8);
        check("g2_wait", state, 8'd4);
        i_btn = oh(c0 ^ 2'b01); cyc(1); i_btn = 4'd0;
        check("wrong_state", state, 8'd6);
        check("wrong_level", level, 8'd1);

        // Waiting for input with no press
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        cyc(9);
        check("to_wait", state, 8'd4);
`ifdef GENIUS_TIMEOUT_EN
        cyc(11);
        check("pre_timeout", state, 8'd4);
        cyc(1);
        check("timeout_lose", state, 8'd6);
`else
        cyc(100);
        check("no_timeout", state, 8'd4);
`endif

        // Win path on the MAX_LEN=2 instance
        w_start = 1'b1; cyc(1); w_start = 1'b0;
        wc0 = m_lfsr[1:0];
        check("w_add", w_state, 8'd1);
        cyc(9);
        check("w_r1_wait", w_state, 8'd4);
        w_btn = oh(wc0); cyc(1); w_btn = 4'd0;
        check("w_r1_gap", w_state, 8'd5);
        cyc(4);
        wc1 = m_lfsr[1:0];
        check("w_r2_add", w_state, 8'd1);
        cyc(17);
        check("w_r2_wait", w_state, 8'd4);
        w_btn = oh(wc0); cyc(1);
        w_btn = oh(wc1); cyc(1); w_btn = 4'd0;
        check("win_state", w_state, 8'd7);
        check("win_flag", w_win, 8'd1);
        check("win_leds0", w_leds, 8'h5);
        check("win_busy", w_busy, 8'd0);
        check("win_level", w_level, 8'd2);
        cyc(3);
        check("win_leds3", w_leds, 8'h5);
        cyc(1);
        check("win_leds4", w_leds, 8'hA);
        w_btn = 4'b0011; cyc(1); w_btn = 4'd0;
        check("win_btn_ignored", w_state, 8'd7);
        cyc(3);
        check("win_leds8", w_leds, 8'h5);
        w_start = 1'b1; cyc(1); w_start = 1'b0;
        check("win_restart", w_state, 8'd1);
        check("win_cleared", w_win, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
